// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg
//   Shared AXI4-Lite definitions for the configuration master: response codes,
//   the write-strobe value used for full-word writes, and the master FSM states.
//   No ports; imported by axi_lite_cfg_master and its bench.
package axi_lite_pkg;

  localparam logic [1:0] AXI_OK     = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;
  localparam logic [1:0] AXI_DECERR = 2'b11;

  // Register-file accesses are always full 32-bit words.
  localparam logic [3:0] AXI_WSTRB_ALL = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RSP
  } axi_m_state_e;

endpackage

// File: rtl/axi_lite_cfg_master.sv
// axi_lite_cfg_master
//   AXI4-Lite initiator that converts a command/response handshake into single
//   AXI-Lite read or write transactions, one outstanding at a time. Intended to
//   drive the pixel_generator register file from a local controller.
//   A watchdog sets a sticky timeout_flag if the slave stalls; the FSM keeps
//   waiting so the bus protocol is never violated.
// Ports
//   s_axi_lite_aclk, periph_resetn  clock, asynchronous active-low reset
//   cmd_*                           command in (valid/ready, write, addr, wdata)
//   rsp_*                           response out (valid/ready, write, rdata, resp)
//   timeout_flag                    sticky watchdog flag, cleared on next command accept
//   m_axi_lite_*                    AXI4-Lite master channels (AW, W, B, AR, R), 32-bit data
module axi_lite_cfg_master
  import axi_lite_pkg::*;
#(
  parameter int AXI_LITE_ADDR_WIDTH = 8,
  parameter int TIMEOUT_CYCLES      = 1024
) (
  input  logic                           s_axi_lite_aclk,
  input  logic                           periph_resetn,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic                           cmd_write,
  input  logic [AXI_LITE_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]                    cmd_wdata,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic                           rsp_write,
  output logic [31:0]                    rsp_rdata,
  output logic [1:0]                     rsp_resp,
  output logic                           timeout_flag,
  output logic [AXI_LITE_ADDR_WIDTH-1:0] m_axi_lite_awaddr,
  output logic                           m_axi_lite_awvalid,
  input  logic                           m_axi_lite_awready,
  output logic [31:0]                    m_axi_lite_wdata,
  output logic [3:0]                     m_axi_lite_wstrb,
  output logic                           m_axi_lite_wvalid,
  input  logic                           m_axi_lite_wready,
  input  logic [1:0]                     m_axi_lite_bresp,
  input  logic                           m_axi_lite_bvalid,
  output logic                           m_axi_lite_bready,
  output logic [AXI_LITE_ADDR_WIDTH-1:0] m_axi_lite_araddr,
  output logic                           m_axi_lite_arvalid,
  input  logic                           m_axi_lite_arready,
  input  logic [31:0]                    m_axi_lite_rdata,
  input  logic [1:0]                     m_axi_lite_rresp,
  input  logic                           m_axi_lite_rvalid,
  output logic                           m_axi_lite_rready
);

  localparam int AW     = AXI_LITE_ADDR_WIDTH;
  localparam bit WDOG_EN = (TIMEOUT_CYCLES > 0);
  localparam int WDOG_W  = WDOG_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT_CYCLES);

  axi_m_state_e state_q, state_d;

  logic          cmd_ready_q, cmd_ready_d;
  logic          write_q, write_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          awvalid_q, awvalid_d;
  logic          wvalid_q, wvalid_d;
  logic          aw_done_q, aw_done_d;
  logic          w_done_q, w_done_d;
  logic          bready_q, bready_d;
  logic          arvalid_q, arvalid_d;
  logic          rready_q, rready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]    rsp_resp_q, rsp_resp_d;
  logic          timeout_q, timeout_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;

  logic accept;
  logic wdog_active;

  // Word-aligned bus addresses: the byte-lane bits never reach the bus.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^cmd_addr[1:0];

  assign accept      = (state_q == IDLE) && cmd_valid;
  assign wdog_active = (state_q != IDLE) && (state_q != RSP);

  // Per-channel completion flags for the write request phase; AW and W may
  // handshake in the same cycle or in either order.
  assign aw_done_d = accept ? 1'b0
                   : (aw_done_q || ((state_q == WR_REQ) && awvalid_q && m_axi_lite_awready));
  assign w_done_d  = accept ? 1'b0
                   : (w_done_q || ((state_q == WR_REQ) && wvalid_q && m_axi_lite_wready));

  // State register
  always_ff @(posedge s_axi_lite_aclk or negedge periph_resetn) begin
    if (!periph_resetn) state_q <= IDLE;
    else                state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid) state_d = cmd_write ? WR_REQ : RD_REQ;
      WR_REQ:  if (aw_done_d && w_done_d) state_d = WR_RESP;
      WR_RESP: if (bready_q && m_axi_lite_bvalid) state_d = RSP;
      RD_REQ:  if (arvalid_q && m_axi_lite_arready) state_d = RD_DATA;
      RD_DATA: if (rready_q && m_axi_lite_rvalid) state_d = RSP;
      RSP:     if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: every output is a flop loaded from the next state, so each
  // strobe appears in the first cycle of the state that owns it.
  always_comb begin
    cmd_ready_d = (state_d == IDLE);
    awvalid_d   = (state_d == WR_REQ) && !aw_done_d;
    wvalid_d    = (state_d == WR_REQ) && !w_done_d;
    bready_d    = (state_d == WR_RESP);
    arvalid_d   = (state_d == RD_REQ);
    rready_d    = (state_d == RD_DATA);
    rsp_valid_d = (state_d == RSP);

    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (accept) begin
      write_d = cmd_write;
      addr_d  = {cmd_addr[AW-1:2], 2'b00};
      wdata_d = cmd_wdata;
    end

    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    if ((state_q == WR_RESP) && bready_q && m_axi_lite_bvalid) begin
      rsp_rdata_d = '0;
      rsp_resp_d  = m_axi_lite_bresp;
    end
    if ((state_q == RD_DATA) && rready_q && m_axi_lite_rvalid) begin
      rsp_rdata_d = m_axi_lite_rdata;
      rsp_resp_d  = m_axi_lite_rresp;
    end

    // Watchdog saturates at the limit; the flag is informational only.
    wdog_d    = wdog_q;
    timeout_d = timeout_q;
    if (accept) begin
      wdog_d    = '0;
      timeout_d = 1'b0;
    end else if (WDOG_EN && wdog_active && (wdog_q != WDOG_MAX)) begin
      wdog_d = wdog_q + 1'b1;
      if (wdog_d == WDOG_MAX) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge s_axi_lite_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      cmd_ready_q <= 1'b1;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= AXI_OK;
      timeout_q   <= 1'b0;
      wdog_q      <= '0;
    end else begin
      cmd_ready_q <= cmd_ready_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      timeout_q   <= timeout_d;
      wdog_q      <= wdog_d;
    end
  end

  assign cmd_ready          = cmd_ready_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_write          = write_q;
  assign rsp_rdata          = rsp_rdata_q;
  assign rsp_resp           = rsp_resp_q;
  assign timeout_flag       = timeout_q;
  assign m_axi_lite_awaddr  = addr_q;
  assign m_axi_lite_awvalid = awvalid_q;
  assign m_axi_lite_wdata   = wdata_q;
  assign m_axi_lite_wstrb   = AXI_WSTRB_ALL;
  assign m_axi_lite_wvalid  = wvalid_q;
  assign m_axi_lite_bready  = bready_q;
  assign m_axi_lite_araddr  = addr_q;
  assign m_axi_lite_arvalid = arvalid_q;
  assign m_axi_lite_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_cfg_master.sv
// tb_axi_lite_cfg_master
//   Directed bench for axi_lite_cfg_master against a small register-file slave
//   model with programmable AW/W ready delays and AR/B stall controls.
module tb_axi_lite_cfg_master;
  import axi_lite_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [7:0]  cmd_addr = 8'h00;
  logic [31:0] cmd_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        timeout_flag;
  logic [7:0]  m_awaddr;
  logic        m_awvalid, m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid, m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid, m_bready;
  logic [7:0]  m_araddr;
  logic        m_arvalid, m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid, m_rready;

  always #5 clk = ~clk;

  axi_lite_cfg_master #(
    .AXI_LITE_ADDR_WIDTH(8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .s_axi_lite_aclk   (clk),
    .periph_resetn     (rstn),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_write         (cmd_write),
    .cmd_addr          (cmd_addr),
    .cmd_wdata         (cmd_wdata),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_write         (rsp_write),
    .rsp_rdata         (rsp_rdata),
    .rsp_resp          (rsp_resp),
    .timeout_flag      (timeout_flag),
    .m_axi_lite_awaddr (m_awaddr),
    .m_axi_lite_awvalid(m_awvalid),
    .m_axi_lite_awready(m_awready),
    .m_axi_lite_wdata  (m_wdata),
    .m_axi_lite_wstrb  (m_wstrb),
    .m_axi_lite_wvalid (m_wvalid),
    .m_axi_lite_wready (m_wready),
    .m_axi_lite_bresp  (m_bresp),
    .m_axi_lite_bvalid (m_bvalid),
    .m_axi_lite_bready (m_bready),
    .m_axi_lite_araddr (m_araddr),
    .m_axi_lite_arvalid(m_arvalid),
    .m_axi_lite_arready(m_arready),
    .m_axi_lite_rdata  (m_rdata),
    .m_axi_lite_rresp  (m_rresp),
    .m_axi_lite_rvalid (m_rvalid),
    .m_axi_lite_rready (m_rready)
  );

  // ---------------- slave model ----------------
  logic [31:0] mem [0:63];
  int          aw_delay = 0, w_delay = 0;
  bit          stall_ar = 1'b0, stall_b = 1'b0;
  int          aw_wait, w_wait;
  logic        aw_have, w_have, b_pend, rvalid_r;
  logic [7:0]  aw_addr_l;
  logic [31:0] w_data_l, rdata_r;
  logic [1:0]  bresp_r, rresp_r;
  int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0;
  logic [7:0]  last_awaddr = 8'h00, last_araddr = 8'h00;
  logic        aw_fire, w_fire, wr_go;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;

  assign m_awready = m_awvalid && !aw_have && !b_pend && (aw_wait >= aw_delay);
  assign m_wready  = m_wvalid && !w_have && !b_pend && (w_wait >= w_delay);
  assign m_bvalid  = b_pend && !stall_b;
  assign m_bresp   = bresp_r;
  assign m_arready = m_arvalid && !stall_ar && !rvalid_r;
  assign m_rvalid  = rvalid_r;
  assign m_rdata   = rdata_r;
  assign m_rresp   = rresp_r;
  assign aw_fire   = m_awvalid && m_awready;
  assign w_fire    = m_wvalid && m_wready;
  assign wr_go     = (aw_have || aw_fire) && (w_have || w_fire);
  assign wr_addr   = aw_fire ? m_awaddr : aw_addr_l;
  assign wr_data   = w_fire ? m_wdata : w_data_l;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_have <= 1'b0; w_have <= 1'b0; aw_wait <= 0; w_wait <= 0;
      b_pend <= 1'b0; rvalid_r <= 1'b0; bresp_r <= 2'b00; rresp_r <= 2'b00;
      rdata_r <= 32'h0; aw_addr_l <= 8'h00; w_data_l <= 32'h0;
    end else begin
      if (m_awvalid && !m_awready && !aw_have) aw_wait <= aw_wait + 1;
      if (m_wvalid && !m_wready && !w_have) w_wait <= w_wait + 1;
      if (aw_fire) begin
        aw_have <= 1'b1; aw_addr_l <= m_awaddr; aw_wait <= 0;
        aw_hs <= aw_hs + 1; last_awaddr <= m_awaddr;
      end
      if (w_fire) begin
        w_have <= 1'b1; w_data_l <= m_wdata; w_wait <= 0; w_hs <= w_hs + 1;
      end
      if (wr_go) begin
        mem[wr_addr[7:2]] <= wr_data;
        b_pend  <= 1'b1;
        bresp_r <= (wr_addr[7:4] == 4'hF) ? AXI_DECERR : AXI_OK;
        aw_have <= 1'b0;
        w_have  <= 1'b0;
      end
      if (m_bvalid && m_bready) begin
        b_pend <= 1'b0; b_hs <= b_hs + 1;
      end
      if (m_arvalid && m_arready) begin
        rvalid_r <= 1'b1;
        rdata_r  <= mem[m_araddr[7:2]];
        rresp_r  <= (m_araddr[7:4] == 4'hF) ? AXI_SLVERR : AXI_OK;
        ar_hs <= ar_hs + 1; last_araddr <= m_araddr;
      end else if (rvalid_r && m_rready) begin
        rvalid_r <= 1'b0;
      end
    end
  end

  // A valid that was waiting must still be high on the next edge.
  int   viol = 0;
  logic aw_pc, w_pc, ar_pc;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_pc <= 1'b0; w_pc <= 1'b0; ar_pc <= 1'b0;
    end else begin
      viol  <= viol + int'(aw_pc && !m_awvalid) + int'(w_pc && !m_wvalid) + int'(ar_pc && !m_arvalid);
      aw_pc <= m_awvalid && !m_awready;
      w_pc  <= m_wvalid && !m_wready;
      ar_pc <= m_arvalid && !m_arready;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking helpers ----------------
  int total = 0;
  int bad = 0;
  int t0 = 0;
  int lat = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present a command at a negedge, hold it until accepted, return one cycle later.
  task automatic issue(input string tag, input logic wr, input logic [7:0] addr,
                       input logic [31:0] data);
    int n;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk({tag, "_accept_wait"}, 32'(cmd_ready), 32'd1);
    t0 = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input logic wr, input logic [31:0] exp_rdata,
                          input logic [1:0] exp_resp, input int hold);
    int n;
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    lat = cyc - t0;
    chk({tag, "_rsp_write"}, 32'(rsp_write), 32'(wr));
    chk({tag, "_rsp_rdata"}, rsp_rdata, exp_rdata);
    chk({tag, "_rsp_resp"}, 32'(rsp_resp), 32'(exp_resp));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
      chk({tag, "_hold_rdata"}, rsp_rdata, exp_rdata);
      chk({tag, "_hold_resp"}, 32'(rsp_resp), 32'(exp_resp));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
    $display("txn %s wr=%0d rdata=0x%08h resp=%0d lat=%0d", tag, wr, rsp_rdata, rsp_resp, lat);
  endtask

  task automatic run_cmd(input string tag, input logic wr, input logic [7:0] addr,
                         input logic [31:0] data, input logic [31:0] exp_rdata,
                         input logic [1:0] exp_resp, input int hold);
    issue(tag, wr, addr, data);
    wait_rsp(tag, wr, exp_rdata, exp_resp, hold);
  endtask

  // ---------------- directed sequence ----------------
  int aw0, w0, b0;
  int n;

  initial begin
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_awvalid", 32'(m_awvalid), 32'd0);
    chk("rst_arvalid", 32'(m_arvalid), 32'd0);
    chk("rst_bready", 32'(m_bready), 32'd0);
    chk("rst_timeout", 32'(timeout_flag), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("wstrb", 32'(m_wstrb), 32'hF);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Basic write/read, zero-wait slave
    run_cmd("wr0", 1'b1, 8'h00, 32'h12345678, 32'h0, AXI_OK, 0);
    chk("wr0_latency", 32'(lat), 32'd3);
    run_cmd("rd0", 1'b0, 8'h00, 32'h0, 32'h12345678, AXI_OK, 0);
    chk("rd0_latency", 32'(lat), 32'd3);

    // AW handshakes three cycles before W
    aw_delay = 0; w_delay = 3;
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
    run_cmd("wr_awfirst", 1'b1, 8'h04, 32'hA5A50001, 32'h0, AXI_OK, 0);
    chk("awfirst_aw_hs", 32'(aw_hs - aw0), 32'd1);
    chk("awfirst_w_hs", 32'(w_hs - w0), 32'd1);
    chk("awfirst_b_hs", 32'(b_hs - b0), 32'd1);
    // W handshakes three cycles before AW
    aw_delay = 3; w_delay = 0;
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
    run_cmd("wr_wfirst", 1'b1, 8'h08, 32'h0BADF00D, 32'h0, AXI_OK, 0);
    chk("wfirst_aw_hs", 32'(aw_hs - aw0), 32'd1);
    chk("wfirst_w_hs", 32'(w_hs - w0), 32'd1);
    chk("wfirst_b_hs", 32'(b_hs - b0), 32'd1);
    aw_delay = 0; w_delay = 0;
    run_cmd("rd_awfirst", 1'b0, 8'h04, 32'h0, 32'hA5A50001, AXI_OK, 0);
    run_cmd("rd_wfirst", 1'b0, 8'h08, 32'h0, 32'h0BADF00D, AXI_OK, 0);

    // Unaligned address is word-aligned on the bus
    run_cmd("wr_unal", 1'b1, 8'h1F, 32'hCAFEBEEF, 32'h0, AXI_OK, 0);
    chk("unal_awaddr", 32'(last_awaddr), 32'h1C);
    run_cmd("rd_1c", 1'b0, 8'h1C, 32'h0, 32'hCAFEBEEF, AXI_OK, 0);
    chk("rd_1c_araddr", 32'(last_araddr), 32'h1C);

    // Slave error codes pass through; writes report rdata 0
    run_cmd("wr_err", 1'b1, 8'hF4, 32'h5555AAAA, 32'h0, AXI_DECERR, 0);
    run_cmd("rd_err", 1'b0, 8'hF6, 32'h0, 32'h5555AAAA, AXI_SLVERR, 0);

    // Response back-pressure
    run_cmd("rd_hold", 1'b0, 8'h00, 32'h0, 32'h12345678, AXI_OK, 10);
    chk("no_timeout_yet", 32'(timeout_flag), 32'd0);

    // Watchdog on a stalled AR channel
    stall_ar = 1'b1;
    issue("rd_stall", 1'b0, 8'h1C, 32'h0);
    repeat (15) @(negedge clk);
    chk("to_before_16", 32'(timeout_flag), 32'd0);
    @(negedge clk);
    chk("to_at_16", 32'(timeout_flag), 32'd1);
    chk("to_arvalid_held", 32'(m_arvalid), 32'd1);
    repeat (5) @(negedge clk);
    chk("to_saturated", 32'(timeout_flag), 32'd1);
    chk("to_arvalid_still", 32'(m_arvalid), 32'd1);
    stall_ar = 1'b0;
    wait_rsp("rd_stall", 1'b0, 32'hCAFEBEEF, AXI_OK, 0);
    chk("to_sticky_idle", 32'(timeout_flag), 32'd1);
    issue("wr_after_to", 1'b1, 8'h20, 32'h00C0FFEE);
    chk("to_cleared_on_accept", 32'(timeout_flag), 32'd0);
    wait_rsp("wr_after_to", 1'b1, 32'h0, AXI_OK, 0);

    // Reset while waiting in WR_RESP
    stall_b = 1'b1;
    issue("wr_abort", 1'b1, 8'h30, 32'hDEAD0001);
    n = 0;
    while (!m_bready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort_in_wr_resp", 32'(m_bready), 32'd1);
    rstn = 1'b0;
    #1;
    chk("abort_bready", 32'(m_bready), 32'd0);
    chk("abort_awvalid", 32'(m_awvalid), 32'd0);
    chk("abort_wvalid", 32'(m_wvalid), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    stall_b = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    run_cmd("wr_post_rst", 1'b1, 8'h30, 32'h600DF00D, 32'h0, AXI_OK, 0);
    run_cmd("rd_post_rst", 1'b0, 8'h30, 32'h0, 32'h600DF00D, AXI_OK, 0);

    chk("protocol_violations", 32'(viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
